branch_redirect_ctrl: RTL and testbench

Sequences PC redirection for taken branches and jumps in the 5-stage RISC-V core. It sits between the EX-stage branch unit (PcSel/BrPC) and the fetch stage and owns the redirect handshake with instruction memory. It generates the IF/ID and ID/EX flush strobes and holds a pending redirect target across instruction-memory back-pressure. It also rejects targets that are misaligned or out of the PC range.

---
 rtl/branch_redirect_ctrl.sv | 131 +++++++++++++
 tb/tb_branch_redirect_ctrl.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/branch_redirect_ctrl.sv
// rtl/branch_redirect_ctrl.sv - EX-stage branch redirect sequencer with imem back-pressure hold (optional BRANCH_PERF_CNT_EN counters)
module branch_redirect_ctrl #(
  parameter int PC_W  = 9,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             ex_valid,
  input  logic             pc_sel,
  input  logic [31:0]      br_pc,
  input  logic             stall_in,
  input  logic             imem_ready,
  output logic             pc_load,
  output logic [PC_W-1:0]  redirect_pc,
  output logic             flush_ifid,
  output logic             flush_idex,
  output logic             busy,
  output logic             target_err,
  output logic [CNT_W-1:0] redirect_cnt,
  output logic [CNT_W-1:0] wait_cnt
);

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [PC_W-1:0] tgt_q;
  logic            err_q;
  logic            take;
  logic            bad;

  // A stalled EX instruction is re-presented later, so it is not a take yet
  assign take = ex_valid & pc_sel & ~stall_in;
  // Targets must be word aligned and fit inside the architectural PC
  assign bad  = (|br_pc[1:0]) | (|br_pc[31:PC_W]);

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: enter WAIT when imem refuses the redirect, leave once it accepts
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (take && !bad && !imem_ready) state_nxt = WAIT;
      WAIT: if (imem_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Hold the target across back-pressure and register the bad-target flag
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tgt_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (state == IDLE && take && !bad && !imem_ready) begin
        tgt_q <= br_pc[PC_W-1:0];
      end
      err_q <= (state == IDLE) & take & bad;
    end
  end

  // Output decode; strobes are masked while reset is held so nothing leaks out
  always_comb begin
    pc_load     = 1'b0;
    redirect_pc = tgt_q;
    flush_ifid  = 1'b0;
    flush_idex  = 1'b0;
    if (reset_n) begin
      case (state)
        IDLE: begin
          if (take && !bad) begin
            pc_load     = imem_ready;
            redirect_pc = br_pc[PC_W-1:0];
            flush_ifid  = 1'b1;
            flush_idex  = 1'b1;
          end
        end
        WAIT: begin
          pc_load    = 1'b1;
          flush_ifid = 1'b1;
          flush_idex = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy       = (state == WAIT);
  assign target_err = err_q;

`ifdef BRANCH_PERF_CNT_EN
  logic [CNT_W-1:0] redirect_cnt_q;
  logic [CNT_W-1:0] wait_cnt_q;
  logic             redirect_done;

  // A redirect completes when the PC load is actually accepted by imem
  assign redirect_done = pc_load & ((state == IDLE) | imem_ready);

  // Saturating performance counters
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      redirect_cnt_q <= '0;
      wait_cnt_q     <= '0;
    end else begin
      if (redirect_done && (redirect_cnt_q != {CNT_W{1'b1}})) begin
        redirect_cnt_q <= redirect_cnt_q + 1'b1;
      end
      if ((state == WAIT) && (wait_cnt_q != {CNT_W{1'b1}})) begin
        wait_cnt_q <= wait_cnt_q + 1'b1;
      end
    end
  end

  assign redirect_cnt = redirect_cnt_q;
  assign wait_cnt     = wait_cnt_q;
`else
  assign redirect_cnt = '0;
  assign wait_cnt     = '0;
`endif

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// tb/tb_branch_redirect_ctrl.sv - scoreboard bench for branch_redirect_ctrl
module tb_branch_redirect_ctrl;

  localparam int PC_W  = 9;
  localparam int CNT_W = 16;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             ex_valid = 1'b0;
  logic             pc_sel = 1'b0;
  logic [31:0]      br_pc = '0;
  logic             stall_in = 1'b0;
  logic             imem_ready = 1'b0;
  logic             pc_load;
  logic [PC_W-1:0]  redirect_pc;
  logic             flush_ifid;
  logic             flush_idex;
  logic             busy;
  logic             target_err;
  logic [CNT_W-1:0] redirect_cnt;
  logic [CNT_W-1:0] wait_cnt;

  branch_redirect_ctrl #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n), .ex_valid(ex_valid), .pc_sel(pc_sel),
    .br_pc(br_pc), .stall_in(stall_in), .imem_ready(imem_ready),
    .pc_load(pc_load), .redirect_pc(redirect_pc), .flush_ifid(flush_ifid),
    .flush_idex(flush_idex), .busy(busy), .target_err(target_err),
    .redirect_cnt(redirect_cnt), .wait_cnt(wait_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit        pc_load;
    bit        chk_pc;
    int        redirect_pc;
    bit        flush;
    bit        busy;
    bit        target_err;
    int        redirect_cnt;
    int        wait_cnt;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference model: a pending redirect target plus a pending error flag
  bit   m_pending = 0;
  int   m_tgt = 0;
  bit   m_err = 0;
  int   m_redir = 0;
  int   m_wait = 0;

  task automatic apply(input bit rn, input bit ev, input bit ps, input int bp,
                       input bit st, input bit rdy);
    exp_t e;
    bit   take;
    bit   bad;
    @(posedge clk);
    #1;
    reset_n = rn; ex_valid = ev; pc_sel = ps; br_pc = bp;
    stall_in = st; imem_ready = rdy;
    e = '{default: 0};
    if (!rn) begin
      m_pending = 0; m_tgt = 0; m_err = 0; m_redir = 0; m_wait = 0;
      e.chk_pc = 1;
    end else begin
      take = ev && ps && !st;
      bad  = ((bp & 3) != 0) || ((bp >>> PC_W) != 0);
      e.busy         = m_pending;
      e.target_err   = m_err;
      e.redirect_cnt = m_redir;
      e.wait_cnt     = m_wait;
      m_err = 0;
      if (m_pending) begin
        e.pc_load = 1; e.chk_pc = 1; e.redirect_pc = m_tgt; e.flush = 1;
        m_wait = (m_wait < CMAX) ? m_wait + 1 : m_wait;
        if (rdy) begin
          m_pending = 0;
          m_redir = (m_redir < CMAX) ? m_redir + 1 : m_redir;
        end
      end else if (take && bad) begin
        m_err = 1;
      end else if (take) begin
        e.flush = 1;
        if (rdy) begin
          e.pc_load = 1; e.chk_pc = 1; e.redirect_pc = bp % (1 << PC_W);
          m_redir = (m_redir < CMAX) ? m_redir + 1 : m_redir;
        end else begin
          m_pending = 1;
          m_tgt = bp % (1 << PC_W);
        end
      end else begin
        e.chk_pc = 1; e.redirect_pc = m_tgt;
      end
`ifndef BRANCH_PERF_CNT_EN
      e.redirect_cnt = 0;
      e.wait_cnt = 0;
`endif
    end
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input int act, input int expv);
    if (act != expv) begin
      miscompares++;
      $display("FAIL %s at vector %0d: got 0x%0h expected 0x%0h", name, vectors, act, expv);
    end
  endtask

  // Monitor: compare DUT outputs mid-cycle against the oldest expectation
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("pc_load", int'(pc_load), int'(e.pc_load));
      if (e.chk_pc) chk("redirect_pc", int'(redirect_pc), e.redirect_pc);
      chk("flush_ifid", int'(flush_ifid), int'(e.flush));
      chk("flush_idex", int'(flush_idex), int'(e.flush));
      chk("busy", int'(busy), int'(e.busy));
      chk("target_err", int'(target_err), int'(e.target_err));
      chk("redirect_cnt", int'(redirect_cnt), e.redirect_cnt);
      chk("wait_cnt", int'(wait_cnt), e.wait_cnt);
      vectors++;
    end
  end

  initial begin
    int bp;
    int sel;
    // reset held with a live take, then released idle
    apply(0, 1, 1, 'h40, 0, 1);
    apply(0, 1, 1, 'h40, 0, 1);
    apply(1, 0, 0, 0, 0, 1);
    apply(1, 0, 0, 0, 0, 1);
    // immediate redirect
    apply(1, 1, 1, 'h40, 0, 1);
    apply(1, 0, 0, 0, 0, 1);
    // back-pressure: three refused cycles then accept
    apply(1, 1, 1, 'h1F0, 0, 0);
    apply(1, 0, 0, 0, 0, 0);
    apply(1, 1, 1, 'h44, 1, 0);
    apply(1, 0, 0, 0, 0, 1);
    apply(1, 0, 0, 0, 0, 1);
    // misaligned and out-of-range targets
    apply(1, 1, 1, 'h42, 0, 1);
    apply(1, 0, 0, 0, 0, 1);
    apply(1, 1, 1, 'h400, 0, 1);
    apply(1, 0, 0, 0, 0, 1);
    apply(1, 0, 0, 0, 0, 1);
    // stalled branch re-presented
    apply(1, 1, 1, 'h80, 1, 1);
    apply(1, 1, 1, 'h80, 1, 1);
    apply(1, 1, 1, 'h80, 0, 1);
    apply(1, 0, 0, 0, 0, 1);
    // reset in the middle of WAIT
    apply(1, 1, 1, 'h80, 0, 0);
    apply(1, 0, 0, 0, 0, 0);
    apply(0, 0, 0, 0, 0, 0);
    apply(1, 0, 0, 0, 0, 1);
    apply(1, 0, 0, 0, 0, 1);
    // back-to-back takes
    apply(1, 1, 1, 'h100, 0, 1);
    apply(1, 1, 1, 'h104, 0, 1);
    apply(1, 0, 0, 0, 0, 1);
    // random traffic
    for (int i = 0; i < 3000; i++) begin
      sel = $urandom_range(0, 9);
      if (sel == 0)      bp = ($urandom & 32'hFFFF_FFFC) | 32'h200;
      else if (sel == 1) bp = ($urandom_range(0, 511)) | 1;
      else               bp = $urandom_range(0, 511) & 32'h1FC;
      apply(($urandom_range(0, 60) != 0), $urandom_range(0, 1), $urandom_range(0, 1),
            bp, ($urandom_range(0, 3) == 0), $urandom_range(0, 1));
    end
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
